// File: rtl/seg_scan_ctrl.sv
// Eight-digit (parameterised) seven-segment scan controller with
// per-slot blanking, brightness window and frame-aligned double buffering.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    led_clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*8-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    input  logic                    load_req,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [7:0]              SEG
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int MW = (CW + 1 > 5) ? CW + 1 : 5;

    // cnt_q/d_q hold the slot position that the next edge registers
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DW-1:0]           d_q, d_d;
    logic                    live_q, live_d;
    logic [NUM_DIGITS*8-1:0] sh_seg_q, sh_seg_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
    logic [3:0]              sh_bri_q, sh_bri_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_start_q, frame_start_d;

    logic          wrap;
    logic          boundary;
    logic          capture;
    logic          lit;
    logic [MW-1:0] cnt_w;
    logic [MW-1:0] off;

    always_comb begin
        wrap     = (cnt_q == CW'(SLOT_CYCLES - 1));
        boundary = (cnt_q == '0) && (d_q == '0);
        // live_q keeps the first edge after reset from counting as a frame end
        capture  = live_q && boundary && load_req;

        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        d_d   = d_q;
        if (wrap) begin
            d_d = (d_q == DW'(NUM_DIGITS - 1)) ? '0 : d_q + 1'b1;
        end
        live_d = 1'b1;

        sh_seg_d = sh_seg_q;
        sh_en_d  = sh_en_q;
        sh_bri_d = sh_bri_q;
        if (capture) begin
            sh_seg_d = seg_in;
            sh_en_d  = digit_en;
            sh_bri_d = brightness;
        end

        cnt_w = MW'(cnt_q);
        off   = cnt_w - MW'(BLANK_CYCLES);
        lit   = (cnt_w >= MW'(BLANK_CYCLES)) && sh_en_d[d_q] &&
                (off < MW'(sh_bri_d));

        an_d  = '1;
        seg_d = 8'hFF;
        if (lit) begin
            an_d  = ~(NUM_DIGITS'(1) << d_q);
            seg_d = sh_seg_d[d_q*8 +: 8];
        end

        frame_start_d = boundary;
        load_ack_d    = capture;
    end

    always_ff @(posedge led_clk) begin
        if (rst) begin
            cnt_q         <= '0;
            d_q           <= '0;
            live_q        <= 1'b0;
            sh_seg_q      <= '1;
            sh_en_q       <= '0;
            sh_bri_q      <= '0;
            an_q          <= '1;
            seg_q         <= 8'hFF;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            d_q           <= d_d;
            live_q        <= live_d;
            sh_seg_q      <= sh_seg_d;
            sh_en_q       <= sh_en_d;
            sh_bri_q      <= sh_bri_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign AN          = an_q;
    assign SEG         = seg_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;

endmodule
